cpu_csr_slave: RTL
==================

Name: cpu_csr_slave

Overview:
- Bus responder for the up_* register interface driven by the tester's CPU master (JTAG-driven host access).
- Decodes byte addresses inside one base window and hosts ID, scratch, control, W1C status and a 64-bit free-running counter with a coherent high-word snapshot.
- Drives the control word to the datapath and collects sticky hardware events into STATUS.
- Returns read data with a fixed, parameterised latency and signals the pending read on up_wait.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base; must be aligned to 2^(ADDR_W+2).
- ADDR_W, 4: word-index width; window size = 2^ADDR_W words.
- RD_LATENCY, 1: cycles from up_rd to valid up_data_rd; legal 1..2 (the master samples 2 cycles after its read pulse).
- ID_VALUE, 32'h5453_4531: constant returned by ID.

Ports:
- up_clk  in  1  clock
- up_rst  in  1  synchronous, active-high reset
- up_wr  in  1  write strobe; one transfer per cycle high
- up_rd  in  1  read strobe; single-cycle pulse per transfer
- up_addr  in  32  byte address; bits[1:0] ignored
- up_data_wr  in  32  write data
- up_data_rd  out  32  read data
- up_wait  out  1  high while a read is pending
- ctrl_q  out  32  CTRL register contents
- hw_event  in  4  level events, OR-ed into STATUS[7:4] each cycle

Behaviour:
- Reset is synchronous, active-high, on up_clk. Reset values: up_data_rd=0, up_wait=0, ctrl_q=0, SCRATCH=0, STATUS=0, counter=0, snapshot=0, read pipeline empty.
- Hit = (up_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]). Offset = up_addr[ADDR_W+1:2].
- Register map (byte offsets):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 SCRATCH: RW.
  - 0x08 CTRL: RW. bit0 cnt_en. bit1 cnt_clr, self-clearing, always reads 0.
  - 0x0C STATUS: W1C.
    - bit0 rd_overrun
    - bit1 unmapped
    - bit2 cnt_wrap
    - [7:4] hw_event
    - all other bits read 0
  - 0x10 CNT_LO: RO, returns cnt[31:0]. The same read loads cnt[63:32] into the snapshot.
  - 0x14 CNT_HI: RO, returns the snapshot, not the live counter.
  - Other in-window offsets: unmapped.
- Writes: take effect at the up_clk edge where up_wr=1 and hit. Writes to RO or unmapped offsets are discarded; unmapped writes set STATUS[1].
- Reads (up_rd=1 and hit, at cycle T):
  - Address is captured at T.
  - up_data_rd is updated at the edge ending cycle T+RD_LATENCY-1, so it is valid from cycle T+RD_LATENCY.
  - up_data_rd then holds until the next read completes.
  - up_wait = up_rd OR pending. It is low from cycle T+RD_LATENCY.
  - Read value is taken at cycle T, i.e. pre-write if up_wr lands in the same cycle.
- Misses (no hit): up_rd is ignored and up_data_rd is unchanged; up_wr is ignored.
- up_rd while a read is pending (RD_LATENCY=2 only): the new read is dropped, STATUS[0] is set, and the first read completes normally.
- up_wr during a pending read: accepted normally.
- Counter:
  - 64-bit; +1 per cycle while cnt_en=1.
  - Wrap from all-ones to 0 sets STATUS[2].
  - Writing CTRL with bit1=1 zeroes the counter on the next cycle; bit0 from the same write still applies.
- STATUS priority: a hardware set in the same cycle as a W1C clear of that bit wins (bit stays 1).
- Reset while a read is pending: the read is aborted, up_wait=0 next cycle, no data is delivered.

Optional Feature:
- Macro: CPU_CSR_BUSERR_EN.
- Defined: an in-window read to an unmapped offset returns 32'hDEAD_BEEF with normal latency and sets STATUS[1].
- Not defined: such reads return 32'h0000_0000 and leave STATUS[1] unchanged; unmapped writes still set STATUS[1].

Test Plan:
- Read ID after reset, RD_LATENCY=1 → up_wait=1 in cycle T only; up_data_rd=32'h5453_4531 in cycle T+1.
- Write SCRATCH=32'hA5A5_0F0F, then read it back → 32'hA5A5_0F0F. Same-cycle write 32'h1 plus read → read returns 32'hA5A5_0F0F, next read returns 32'h1.
- CTRL=1 for 10 cycles, then CTRL=0, then read CNT_LO → 10. Read CNT_HI → 0. Write CTRL=2 → next CNT_LO read returns 0, and CTRL reads 0.
- Drive counter to 64'hFFFF_FFFF_FFFF_FFFE, then set cnt_en → STATUS[2]=1 after wrap. Write STATUS=4 → reads 0. Hold hw_event[1]=1 during a W1C of STATUS=32'h20 → STATUS[5] stays 1.
- RD_LATENCY=2, up_rd at T and T+1 → one completion at T+2, STATUS[0]=1.
- Read offset 0x3C → 32'hDEAD_BEEF and STATUS[1]=1 with the macro defined; 0 and STATUS[1]=0 without it.
- Assert up_rst one cycle after up_rd with RD_LATENCY=2 → up_wait=0 and up_data_rd=0 after reset.

Source files
------------

// File: rtl/cpu_csr_slave.sv
// cpu_csr_slave: up_* bus responder hosting ID, SCRATCH, CTRL, W1C STATUS and a
// 64-bit free-running counter with a coherent high-word snapshot.
// Read data appears RD_LATENCY (1 or 2) cycles after the read strobe; up_wait
// covers the whole time a read is outstanding.
// Optional build macro CPU_CSR_BUSERR_EN: in-window reads of unmapped offsets
// return 32'hDEAD_BEEF and flag STATUS[1]; without it they return zero silently.
module cpu_csr_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_W     = 4,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] ID_VALUE   = 32'h5453_4531
) (
    input  logic        up_clk,
    input  logic        up_rst,
    input  logic        up_wr,
    input  logic        up_rd,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_data_wr,
    output logic [31:0] up_data_rd,
    output logic        up_wait,
    output logic [31:0] ctrl_q,
    input  logic [3:0]  hw_event
);

    localparam logic [ADDR_W-1:0] OFF_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_SCRATCH = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_CTRL    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_STATUS  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] OFF_CNT_LO  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] OFF_CNT_HI  = ADDR_W'(5);

    // STATUS bit 3 does not exist; this mask keeps it at zero
    localparam logic [7:0] STATUS_MASK = 8'hF7;

    logic              hit;
    logic [ADDR_W-1:0] offset;
    logic              rd_hit;
    logic              wr_hit;
    logic              rd_accept;
    logic              pending;
    logic              mapped;
    logic [31:0]       rd_value;
    logic [31:0]       scratch;
    logic [63:0]       cnt;
    logic [31:0]       cnt_snap;
    logic [7:0]        status;
    logic [7:0]        status_set;
    logic [7:0]        status_clr;
    logic              clr_req;
    logic              cnt_wrap;
    logic              overrun;
    logic              unmapped_set;
    logic              unused_addr_bits;

    // byte lanes are not supported, so the two lowest address bits carry no information
    assign unused_addr_bits = ^up_addr[1:0];

    // Address decode and strobe qualification; a second read during a pending one is refused
    always_comb begin
        hit       = (up_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
        offset    = up_addr[ADDR_W+1:2];
        rd_hit    = up_rd & hit;
        wr_hit    = up_wr & hit;
        rd_accept = rd_hit & ~pending;
        overrun   = rd_hit & pending;
    end

    assign up_wait = rd_hit | pending;

    // Read mux: value is taken from the registers as they stand in the read cycle
    always_comb begin
        rd_value = 32'h0000_0000;
        mapped   = 1'b1;
        case (offset)
            OFF_ID:      rd_value = ID_VALUE;
            OFF_SCRATCH: rd_value = scratch;
            OFF_CTRL:    rd_value = ctrl_q;
            OFF_STATUS:  rd_value = {24'h0, status};
            OFF_CNT_LO:  rd_value = cnt[31:0];
            OFF_CNT_HI:  rd_value = cnt_snap;
            default: begin
                mapped = 1'b0;
`ifdef CPU_CSR_BUSERR_EN
                rd_value = 32'hDEAD_BEEF;
`else
                rd_value = 32'h0000_0000;
`endif
            end
        endcase
    end

    // Event collection: counter clear request, wrap detection and STATUS set/clear vectors
    always_comb begin
        clr_req  = wr_hit & (offset == OFF_CTRL) & up_data_wr[1];
        cnt_wrap = ctrl_q[0] & ~clr_req & (&cnt);
`ifdef CPU_CSR_BUSERR_EN
        unmapped_set = (wr_hit & ~mapped) | (rd_accept & ~mapped);
`else
        unmapped_set = wr_hit & ~mapped;
`endif
        status_set = {hw_event, 1'b0, cnt_wrap, unmapped_set, overrun};
        status_clr = (wr_hit && offset == OFF_STATUS) ? up_data_wr[7:0] : 8'h00;
    end

    // Writable registers; cnt_clr is never stored so CTRL bit 1 always reads back zero
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            scratch <= 32'h0;
            ctrl_q  <= 32'h0;
        end else if (wr_hit) begin
            if (offset == OFF_SCRATCH) begin
                scratch <= up_data_wr;
            end
            if (offset == OFF_CTRL) begin
                ctrl_q <= {up_data_wr[31:2], 1'b0, up_data_wr[0]};
            end
        end
    end

    // STATUS: hardware sets win over a same-cycle write-one-to-clear
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            status <= 8'h00;
        end else begin
            status <= ((status & ~status_clr) | status_set) & STATUS_MASK;
        end
    end

    // Free-running counter; a clear request overrides counting for that edge
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            cnt <= 64'h0;
        end else if (clr_req) begin
            cnt <= 64'h0;
        end else if (ctrl_q[0]) begin
            cnt <= cnt + 64'h1;
        end
    end

    // High-word snapshot taken by an accepted CNT_LO read so a LO/HI pair is coherent
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            cnt_snap <= 32'h0;
        end else if (rd_accept && offset == OFF_CNT_LO) begin
            cnt_snap <= cnt[63:32];
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            logic [31:0] rd_hold;

            // Two-stage read: capture in the request cycle, deliver one cycle later
            always_ff @(posedge up_clk) begin
                if (up_rst) begin
                    pending    <= 1'b0;
                    rd_hold    <= 32'h0;
                    up_data_rd <= 32'h0;
                end else begin
                    if (pending) begin
                        up_data_rd <= rd_hold;
                        pending    <= 1'b0;
                    end
                    if (rd_accept) begin
                        rd_hold <= rd_value;
                        pending <= 1'b1;
                    end
                end
            end
        end else begin : g_lat1
            assign pending = 1'b0;

            // Single-stage read: data lands at the edge ending the request cycle
            always_ff @(posedge up_clk) begin
                if (up_rst) begin
                    up_data_rd <= 32'h0;
                end else if (rd_accept) begin
                    up_data_rd <= rd_value;
                end
            end
        end
    endgenerate

endmodule
